// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/sequencing stage in front of the registered 64-bit ALU.
// Accepts one op over valid/ready, holds operands and ctrl on the ALU inputs,
// pulses the ALU result-register enable after the op-dependent settle time,
// captures the registered result and returns it over a second valid/ready.
// Optional feature macro: ALU_ISSUE_DIVZERO_TRAP_EN (divide by zero trapped
// at accept, returning all ones with out_err set instead of issuing).
module alu_issue_ctrl #(
  parameter int WIDTH         = 64,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_ctrl,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPTURE, DONE} state_t;

  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_LAST = 5'b01011;
  localparam logic [3:0] MD_CNT  = 4'(MULDIV_CYCLES);

  state_t             state, state_nxt;
  logic [4:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         cnt;
  logic [WIDTH-1:0]   res_q;
  logic               err_q;
  logic               vld_q;

  logic               accept;
  logic               illegal;
  logic               divz;
  logic               skip;
  logic [3:0]         cnt_load;
  logic [WIDTH-1:0]   skip_res;

  assign in_ready = (state == IDLE) && clr;
  assign busy     = (state != IDLE);
  // flush wins over a simultaneous in_valid, so no accept happens under it
  assign accept   = in_valid && in_ready && !flush;
  assign illegal  = (in_op > OP_LAST);

`ifdef ALU_ISSUE_DIVZERO_TRAP_EN
  assign divz = (in_op == OP_DIV) && (in_b == '0);
`else
  assign divz = 1'b0;
`endif

  // ops that never reach the ALU go straight to DONE with an error result
  assign skip     = illegal || divz;
  assign skip_res = divz ? {WIDTH{1'b1}} : '0;
  assign cnt_load = ((in_op == OP_MUL) || (in_op == OP_DIV)) ? MD_CNT : 4'd1;

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = op_q;
  assign out_valid  = vld_q;
  assign out_result = res_q;
  assign out_err    = err_q;

  // state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state logic and the combinational result-register enable
  always_comb begin
    state_nxt  = state;
    alu_enable = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = skip ? DONE : EXEC;
      end
      EXEC: begin
        if (cnt == 4'd1) begin
          alu_enable = 1'b1;
          state_nxt  = CAPTURE;
        end
      end
      CAPTURE: state_nxt = DONE;
      DONE: begin
        if (vld_q && out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt  = IDLE;
      alu_enable = 1'b0;
    end
  end

  // op and operand latches, held on the ALU inputs until the next accept
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= in_op;
      a_q  <= in_a;
      b_q  <= in_b;
    end
  end

  // settle counter: loaded on accept, counts down through EXEC, stops at 0
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept && !skip) begin
      cnt <= cnt_load;
    end else if ((state == EXEC) && (cnt != '0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // result capture and downstream valid, held until the output handshake
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      res_q <= '0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (accept && skip) begin
      res_q <= skip_res;
      err_q <= 1'b1;
      vld_q <= 1'b1;
    end else if (state == CAPTURE) begin
      res_q <= alu_result;
      err_q <= 1'b0;
      vld_q <= 1'b1;
    end else if ((state == DONE) && out_ready) begin
      vld_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed scenarios plus randomized traffic for
// alu_issue_ctrl, checked every cycle against a cycle-count reference model,
// with a simple registered ALU model attached to the ALU-side ports.
module tb_alu_issue_ctrl;

  localparam int W  = 64;
  localparam int MD = 4;

`ifdef ALU_ISSUE_DIVZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr, flush, in_valid, out_ready;
  logic          in_ready, alu_enable, out_valid, out_err, busy;
  logic [4:0]    in_op, alu_ctrl;
  logic [W-1:0]  in_a, in_b, alu_a, alu_b, out_result;
  logic [W-1:0]  alu_reg = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: 0 idle, 1 in flight (cycle k after accept), 2 result held
  int           m_mode = 0;
  int           m_k    = 0;
  int           m_en   = 0;
  logic [W-1:0] m_res  = '0;
  logic         m_err  = 1'b0;
  logic [W-1:0] m_a    = '0;
  logic [W-1:0] m_b    = '0;
  logic [4:0]   m_op   = '0;

  alu_issue_ctrl #(.WIDTH(W), .MULDIV_CYCLES(MD)) dut (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_enable(alu_enable), .alu_result(alu_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [4:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a * b;
      5'd3:  return (b == '0) ? {W{1'b1}} : a / b;
      5'd4:  return a & b;
      5'd5:  return a | b;
      5'd6:  return a ^ b;
      5'd7:  return a << b[5:0];
      5'd8:  return a >> b[5:0];
      5'd9:  return W'($signed(a) >>> b[5:0]);
      5'd10: return {63'd0, $signed(a) < $signed(b)};
      5'd11: return {63'd0, a < b};
      default: return '0;
    endcase
  endfunction

  // registered ALU: loads its result register when enabled
  always @(posedge clk) begin
    if (alu_enable) alu_reg <= alu_f(alu_ctrl, alu_a, alu_b);
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // one clock cycle: drive inputs, compare outputs with the model, advance model
  task automatic step(input logic c, input logic f, input logic iv,
                      input logic [4:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic ordy);
    @(negedge clk);
    clr = c; flush = f; in_valid = iv; in_op = op; in_a = a; in_b = b; out_ready = ordy;
    if (!c) begin
      m_mode = 0; m_k = 0; m_en = 0; m_res = '0; m_err = 1'b0;
      m_a = '0; m_b = '0; m_op = '0;
    end
    #1;
    chk("in_ready",   in_ready,   (m_mode == 0) && c);
    chk("busy",       busy,       m_mode != 0);
    chk("alu_enable", alu_enable, (m_mode == 1) && (m_k == m_en) && !f && c);
    chk("out_valid",  out_valid,  m_mode == 2);
    chk("alu_a",      alu_a,      m_a);
    chk("alu_b",      alu_b,      m_b);
    chk("alu_ctrl",   alu_ctrl,   m_op);
    if (m_mode == 2 || !c) begin
      chk("out_result", out_result, m_res);
      chk("out_err",    out_err,    m_err);
    end
    if (c) begin
      if (f) begin
        m_mode = 0;
      end else begin
        case (m_mode)
          0: if (iv) begin
            m_a = a; m_b = b; m_op = op;
            if (op > 5'd11) begin
              m_mode = 2; m_res = '0; m_err = 1'b1;
            end else if (TRAP && op == 5'd3 && b == '0) begin
              m_mode = 2; m_res = {W{1'b1}}; m_err = 1'b1;
            end else begin
              m_mode = 1; m_k = 1;
              m_en = (op == 5'd2 || op == 5'd3) ? MD : 1;
              m_res = alu_f(op, a, b); m_err = 1'b0;
            end
          end
          1: if (m_k == m_en + 1) m_mode = 2; else m_k++;
          default: if (ordy) m_mode = 0;
        endcase
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b1, 1'b0, 1'b0, 5'd0, '0, '0, ordy);
  endtask

  initial begin
    logic [4:0] rop;
    logic [W-1:0] ra, rb;
    clr = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_a = '0; in_b = '0; out_ready = 1'b0;

    // reset state
    step(1'b0, 1'b0, 1'b1, 5'd0, 64'd1, 64'd2, 1'b1);
    step(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_alu_a", alu_a, 64'd0);
    idle(1'b1);

    // add 5+7
    step(1'b1, 1'b0, 1'b1, 5'd0, 64'd5, 64'd7, 1'b1);
    idle(1'b1); chk("t1_enable", alu_enable, 1'b1);
    idle(1'b1); chk("t1_enable_once", alu_enable, 1'b0);
    idle(1'b1); chk("t1_valid", out_valid, 1'b1); chk("t1_result", out_result, 64'd12);
    chk("t1_err", out_err, 1'b0);
    idle(1'b1); chk("t1_ready_again", in_ready, 1'b1);

    // multiply 6*9
    step(1'b1, 1'b0, 1'b1, 5'd2, 64'd6, 64'd9, 1'b1);
    for (int i = 1; i <= MD; i++) begin
      idle(1'b1);
      chk("t2_ctrl", alu_ctrl, 5'd2);
      chk("t2_a", alu_a, 64'd6);
      chk("t2_en", alu_enable, i == MD);
    end
    idle(1'b1); chk("t2_not_yet", out_valid, 1'b0);
    idle(1'b1); chk("t2_valid", out_valid, 1'b1); chk("t2_result", out_result, 64'd54);

    // subtract with backpressure; next op held on in_valid meanwhile
    idle(1'b1);
    step(1'b1, 1'b0, 1'b1, 5'd1, 64'd10, 64'd3, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd0, 64'd1, 64'd1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd0, 64'd1, 64'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 5'd0, 64'd1, 64'd1, 1'b0);
      chk("t3_held_valid", out_valid, 1'b1);
      chk("t3_held_result", out_result, 64'd7);
      chk("t3_no_accept", in_ready, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1, 5'd0, 64'd1, 64'd1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 5'd0, 64'd1, 64'd1, 1'b1);
    chk("t3_accept_after", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("t3_second", out_result, 64'd2);

    // illegal opcode
    idle(1'b1);
    step(1'b1, 1'b0, 1'b1, 5'b01111, 64'd3, 64'd4, 1'b1);
    idle(1'b1);
    chk("t4_valid", out_valid, 1'b1); chk("t4_err", out_err, 1'b1);
    chk("t4_result", out_result, 64'd0); chk("t4_no_en", alu_enable, 1'b0);
    idle(1'b1);

    // flush during divide EXEC
    step(1'b1, 1'b0, 1'b1, 5'd3, 64'd8, 64'd2, 1'b1);
    idle(1'b1);
    step(1'b1, 1'b1, 1'b1, 5'd0, 64'd1, 64'd1, 1'b1);
    chk("t5_flush_no_en", alu_enable, 1'b0);
    for (int i = 0; i < MD + 3; i++) begin
      idle(1'b1);
      chk("t5_flush_no_valid", out_valid, 1'b0);
      chk("t5_flush_idle", in_ready, 1'b1);
    end
    // reset during divide EXEC
    step(1'b1, 1'b0, 1'b1, 5'd3, 64'd8, 64'd2, 1'b1);
    idle(1'b1);
    step(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, 1'b1);
    chk("t5_rst_ready", in_ready, 1'b0); chk("t5_rst_busy", busy, 1'b0);
    for (int i = 0; i < MD + 3; i++) begin
      idle(1'b1);
      chk("t5_rst_ready_after", in_ready, 1'b1);
      chk("t5_rst_no_en", alu_enable, 1'b0);
    end

    // divide by zero
    step(1'b1, 1'b0, 1'b1, 5'd3, 64'd8, 64'd0, 1'b1);
    if (TRAP) begin
      idle(1'b1);
      chk("t6_trap_valid", out_valid, 1'b1); chk("t6_trap_err", out_err, 1'b1);
      chk("t6_trap_result", out_result, {W{1'b1}}); chk("t6_trap_no_en", alu_enable, 1'b0);
    end else begin
      for (int i = 1; i <= MD; i++) begin
        idle(1'b1);
        chk("t6_en", alu_enable, i == MD);
      end
      idle(1'b1);
      idle(1'b1);
      chk("t6_valid", out_valid, 1'b1); chk("t6_err", out_err, 1'b0);
    end
    idle(1'b1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(12, 31)) : 5'($urandom_range(0, 11));
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 5) == 0) ? '0 : {32'($urandom_range(0, 3) == 0 ? $urandom : 0), $urandom};
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 2) != 0), rop, ra, rb, ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 12; i++) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
